// File: rtl/video_render_if.sv
// Fetch-to-render bus: pixel/fetch strobes, mode controls and the palette index output.
// Optional VIDEO_XSCALE_EN adds the xscale (pixel doubling) control.
interface video_render_if;
  logic        pix_stb;
  logic        vactive;
  logic        fetch_stb;
  logic [31:0] fetch_data;
  logic [1:0]  mode;
  logic [3:0]  gpal;
  logic [7:0]  border;
  logic        flash;
`ifdef VIDEO_XSCALE_EN
  logic        xscale;
`endif
  logic [7:0]  vplex;
  logic        underrun;

  modport master (
`ifdef VIDEO_XSCALE_EN
    output xscale,
`endif
    output pix_stb, vactive, fetch_stb, fetch_data, mode, gpal, border, flash,
    input  vplex, underrun
  );

  modport slave (
`ifdef VIDEO_XSCALE_EN
    input  xscale,
`endif
    input  pix_stb, vactive, fetch_stb, fetch_data, mode, gpal, border, flash,
    output vplex, underrun
  );
endinterface

// File: rtl/video_render.sv
// Serialises 32-bit fetch words into 8-bit palette indices (ZX / 16c / 256c / border-only).
// Optional VIDEO_XSCALE_EN: xscale=1 emits each pixel on two consecutive qualifying strobes.
module video_render #(
  parameter bit BORDER_ON_UNDERRUN = 1'b1
) (
  input logic           clk,
  input logic           res,
  video_render_if.slave bus
);

  localparam logic [1:0] MODE_ZX     = 2'd0;
  localparam logic [1:0] MODE_16C    = 2'd1;
  localparam logic [1:0] MODE_256C   = 2'd2;
  localparam logic [1:0] MODE_BORDER = 2'd3;

  logic [31:0] word_q, word_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        word_valid_q, word_valid_d;
  logic [7:0]  vplex_q, vplex_d;
  logic [7:0]  last_pix_q, last_pix_d;
  logic        underrun_q, underrun_d;
`ifdef VIDEO_XSCALE_EN
  logic        half_q, half_d;
`endif

  logic [4:0]  len;
  logic [7:0]  pix;
  logic [7:0]  zx_bm, zx_attr, byte16, byte256;
  logic [2:0]  bit_idx;
  logic        zx_bit, zx_sel;
  logic        advance;

  // Pixels per word in the current mode.
  always_comb begin
    unique case (bus.mode)
      MODE_ZX:  len = 5'd16;
      MODE_16C: len = 5'd8;
      default:  len = 5'd4;
    endcase
  end

  // Pixel at position cnt_q of the held word; bits are taken MSB-first within each byte.
  always_comb begin
    zx_bm   = cnt_q[3] ? word_q[15:8]  : word_q[7:0];
    zx_attr = cnt_q[3] ? word_q[31:24] : word_q[23:16];
    bit_idx = 3'd7 - cnt_q[2:0];
    zx_bit  = zx_bm[bit_idx];
    zx_sel  = zx_bit ^ (zx_attr[7] & bus.flash);
    byte16  = word_q[{cnt_q[2:1], 3'b000} +: 8];
    byte256 = word_q[{cnt_q[1:0], 3'b000} +: 8];
    unique case (bus.mode)
      MODE_ZX:   pix = {bus.gpal, zx_attr[6], zx_sel ? zx_attr[2:0] : zx_attr[5:3]};
      MODE_16C:  pix = {bus.gpal, cnt_q[0] ? byte16[3:0] : byte16[7:4]};
      MODE_256C: pix = byte256;
      default:   pix = bus.border;
    endcase
  end

  always_comb begin
    word_d       = word_q;
    cnt_d        = cnt_q;
    word_valid_d = word_valid_q;
    vplex_d      = vplex_q;
    last_pix_d   = last_pix_q;
    underrun_d   = underrun_q;
    advance      = 1'b0;
`ifdef VIDEO_XSCALE_EN
    half_d       = half_q;
`endif

    if (bus.pix_stb) begin
      if (bus.mode == MODE_BORDER || !bus.vactive) begin
        vplex_d = bus.border;
      end else if (!word_valid_q) begin
        underrun_d = 1'b1;
        vplex_d    = BORDER_ON_UNDERRUN ? bus.border : last_pix_q;
      end else if ({1'b0, cnt_q} >= len) begin
        // Mode shrank the word under us: drop the remainder without emitting.
        word_valid_d = 1'b0;
        cnt_d        = '0;
      end else begin
        vplex_d    = pix;
        last_pix_d = pix;
`ifdef VIDEO_XSCALE_EN
        advance    = !(bus.xscale && !half_q);
        half_d     = bus.xscale && !half_q;
`else
        advance    = 1'b1;
`endif
      end
    end

    if (advance) begin
      if ({1'b0, cnt_q} == len - 5'd1) begin
        word_valid_d = 1'b0;
        cnt_d        = '0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end

    // Load wins over consumption; the pixel above already came from the old word.
    if (bus.fetch_stb) begin
      word_d       = bus.fetch_data;
      word_valid_d = 1'b1;
      cnt_d        = '0;
`ifdef VIDEO_XSCALE_EN
      half_d       = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      word_q       <= '0;
      cnt_q        <= '0;
      word_valid_q <= 1'b0;
      vplex_q      <= '0;
      last_pix_q   <= '0;
      underrun_q   <= 1'b0;
`ifdef VIDEO_XSCALE_EN
      half_q       <= 1'b0;
`endif
    end else begin
      word_q       <= word_d;
      cnt_q        <= cnt_d;
      word_valid_q <= word_valid_d;
      vplex_q      <= vplex_d;
      last_pix_q   <= last_pix_d;
      underrun_q   <= underrun_d;
`ifdef VIDEO_XSCALE_EN
      half_q       <= half_d;
`endif
    end
  end

  assign bus.vplex    = vplex_q;
  assign bus.underrun = underrun_q;

endmodule
